alu_cmd_responder: RTL and testbench
====================================

ALU_CMD_RESPONDER -- requirements
Module: alu_cmd_responder

Interface
REQ-001 Parameter DATA_WIDTH_P, default 8, byte width of both streams.
REQ-002 Parameter ACC_WIDTH_P, default 32, operand/accumulator width; SHALL be a multiple of DATA_WIDTH_P.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_tdata_i  input  DATA_WIDTH_P  command byte, from UART receive stream.
REQ-006 rx_tvalid_i  input  1  rx byte valid.
REQ-007 rx_tready_o  output  1  block accepts rx byte.
REQ-008 tx_tdata_o  output  DATA_WIDTH_P  response byte, to UART transmit stream.
REQ-009 tx_tvalid_o  output  1  response byte valid.
REQ-010 tx_tready_i  input  1  UART transmitter accepts byte.
REQ-011 busy_o  output  1  high in any state other than HDR0.

Function
REQ-012 Byte transfers SHALL occur only when tvalid and tready are both high on a rising edge; tx_tdata_o/tx_tvalid_o SHALL hold stable until accepted.
REQ-013 Packet format: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then payload; length counts all bytes including the 4-byte header.
REQ-014 FSM states: HDR0, HDR1, HDR2, HDR3, PAYLOAD, RESP; HDRn advances on each accepted byte; HDR3 goes to PAYLOAD if length > 4, else directly to RESP (add/mul) or HDR0 (echo/unknown).
REQ-015 Length < 4 SHALL be treated as 4 (header only, no payload).
REQ-016 Opcode 0xEC (echo): in PAYLOAD each payload byte SHALL be forwarded unchanged; rx_tready_o = tx_tready_i, tx_tvalid_o = rx_tvalid_i, zero added latency; no RESP phase.
REQ-017 Opcode 0xA0 (add): accumulator reset to 0 at HDR3; payload assembled little-endian into ACC_WIDTH_P operands; each complete operand added modulo 2^ACC_WIDTH_P the cycle after its last byte is accepted.
REQ-018 Trailing payload bytes not forming a full operand SHALL be consumed and ignored.
REQ-019 RESP SHALL emit ACC_WIDTH_P/DATA_WIDTH_P result bytes, least significant first, then return to HDR0; rx_tready_o SHALL be 0 throughout RESP.
REQ-020 Zero complete operands: add result SHALL be 0.
REQ-021 Unknown opcode: payload consumed with rx_tready_o = 1, no response bytes, return to HDR0.
REQ-022 The byte counter SHALL be 16 bits and SHALL NOT wrap; length 0xFFFF consumes exactly 0xFFFB payload bytes.
REQ-023 First RESP byte SHALL be valid no later than 2 cycles after the last payload byte is accepted.

Reset
REQ-024 While rst is high: state HDR0, accumulator 0, byte counter 0, rx_tready_o 0, tx_tvalid_o 0, tx_tdata_o 0, busy_o 0.
REQ-025 rst asserted mid-packet or mid-response SHALL abort it; no further bytes of that response SHALL be emitted.
REQ-026 rx_tready_o SHALL be 1 in HDR0–HDR3 from the first cycle after rst deasserts.

Configuration
REQ-027 Macro ALU_CMD_MUL_EN: when defined, opcode 0xB0 (multiply) SHALL be supported: accumulator initialised to 1, each operand multiplied in modulo 2^ACC_WIDTH_P, zero operands give 1, response as REQ-019.
REQ-028 Without ALU_CMD_MUL_EN, 0xB0 SHALL be handled as an unknown opcode (REQ-021) and no multiplier SHALL be synthesised.

Structure
REQ-029 Package alu_cmd_pkg SHALL hold the opcode constants (ECHO 0xEC, ADD 0xA0, MUL 0xB0), the header length constant 4, and the FSM state enum typedef.
REQ-030 Sub-module alu_cmd_operand_asm SHALL assemble bytes into little-endian operands and pulse operand-valid; all other logic stays in alu_cmd_responder.

Verification
REQ-031 Echo: EC 00 07 00 41 42 43 -> tx bytes 41 42 43, then busy_o low.
REQ-032 Add: A0 00 0C 00 01 00 00 00 FF FF FF FF -> tx 00 00 00 00 (wrap-around).
REQ-033 Add with trailing bytes: A0 00 0A 00 05 00 00 00 09 09 -> tx 05 00 00 00; next packet parsed correctly.
REQ-034 Unknown opcode: 55 00 06 00 AA BB -> no tx bytes; following EC 00 05 00 7E -> tx 7E.
REQ-035 Backpressure: add response with tx_tready_i toggled every other cycle -> each byte held stable until accepted, correct order.
REQ-036 Reset mid-response and (ALU_CMD_MUL_EN defined) B0 00 0C 00 03 00 00 00 05 00 00 00 -> tx 0F 00 00 00; abort emits no stale bytes.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared constants and FSM state type for the ALU command responder.
// Optional multiply support is selected by the ALU_CMD_MUL_EN macro.
package alu_cmd_pkg;

  localparam logic [7:0]  OP_ECHO = 8'hEC;
  localparam logic [7:0]  OP_ADD  = 8'hA0;
  localparam logic [7:0]  OP_MUL  = 8'hB0;
  localparam logic [15:0] HDR_LEN = 16'd4;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_PAYLOAD,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Receive/transmit byte streams between the UART and the ALU command responder.
interface alu_cmd_responder_if #(
  parameter int unsigned DATA_WIDTH_P = 8
);

  logic [DATA_WIDTH_P-1:0] rx_tdata_i;
  logic                    rx_tvalid_i;
  logic                    rx_tready_o;
  logic [DATA_WIDTH_P-1:0] tx_tdata_o;
  logic                    tx_tvalid_o;
  logic                    tx_tready_i;

  modport slave (
    input  rx_tdata_i, rx_tvalid_i, tx_tready_i,
    output rx_tready_o, tx_tdata_o, tx_tvalid_o
  );

  modport master (
    output rx_tdata_i, rx_tvalid_i, tx_tready_i,
    input  rx_tready_o, tx_tdata_o, tx_tvalid_o
  );

endinterface

// File: rtl/alu_cmd_operand_asm.sv
// Packs payload bytes little-endian into ACC_WIDTH_P operands and pulses
// operand_valid_o for one cycle after the last byte of each operand.
module alu_cmd_operand_asm #(
  parameter int unsigned DATA_WIDTH_P = 8,
  parameter int unsigned ACC_WIDTH_P  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    byte_valid_i,
  input  logic [DATA_WIDTH_P-1:0] byte_i,
  output logic [ACC_WIDTH_P-1:0]  operand_o,
  output logic                    operand_valid_o
);

  localparam int unsigned NBYTES = ACC_WIDTH_P / DATA_WIDTH_P;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ACC_WIDTH_P-1:0] opnd_q, opnd_d;
  logic                   vld_q, vld_d;
  logic [ACC_WIDTH_P-1:0] byte_ext;

  // New bytes enter at the top and shift down, so the first byte ends up least significant.
  always_comb begin
    idx_d    = idx_q;
    opnd_d   = opnd_q;
    vld_d    = 1'b0;
    byte_ext = '0;
    byte_ext[DATA_WIDTH_P-1:0] = byte_i;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      opnd_d = (opnd_q >> DATA_WIDTH_P) | (byte_ext << (ACC_WIDTH_P - DATA_WIDTH_P));
      if (idx_q == IDX_W'(NBYTES - 1)) begin
        idx_d = '0;
        vld_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      opnd_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      opnd_q <= opnd_d;
      vld_q  <= vld_d;
    end
  end

  assign operand_o       = opnd_q;
  assign operand_valid_o = vld_q;

endmodule

// File: rtl/alu_cmd_responder.sv
// Parses opcode/length packets from the UART stream: echo, add, and (with
// ALU_CMD_MUL_EN defined) multiply, returning accumulator bytes LSB first.
module alu_cmd_responder
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P = 8,
  parameter int unsigned ACC_WIDTH_P  = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_responder_if.slave  bus,
  output logic                busy_o
);

  localparam int unsigned NBYTES = ACC_WIDTH_P / DATA_WIDTH_P;
  localparam int unsigned RIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e                 state_q, state_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [ACC_WIDTH_P-1:0] acc_q, acc_d;
  logic [RIDX_W-1:0]      ridx_q, ridx_d;

  logic                   rx_fire, tx_fire;
  logic                   is_echo, is_add, is_mul, is_arith;
  logic [15:0]            len_full;
  logic                   asm_clear, asm_byte_valid;
  logic [ACC_WIDTH_P-1:0] operand;
  logic                   operand_valid;

  assign rx_fire  = bus.rx_tvalid_i && bus.rx_tready_o;
  assign tx_fire  = bus.tx_tvalid_o && bus.tx_tready_i;
  assign len_full = {bus.rx_tdata_i[7:0], len_lo_q};
  assign is_echo  = (opcode_q == OP_ECHO);
  assign is_add   = (opcode_q == OP_ADD);
`ifdef ALU_CMD_MUL_EN
  assign is_mul   = (opcode_q == OP_MUL);
`else
  assign is_mul   = 1'b0;
`endif
  assign is_arith = is_add || is_mul;

  alu_cmd_operand_asm #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ACC_WIDTH_P  (ACC_WIDTH_P)
  ) u_operand_asm (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (asm_clear),
    .byte_valid_i    (asm_byte_valid),
    .byte_i          (bus.rx_tdata_i),
    .operand_o       (operand),
    .operand_valid_o (operand_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HDR0;
      opcode_q <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      ridx_q   <= ridx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    len_lo_d       = len_lo_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    ridx_d         = ridx_q;
    asm_clear      = 1'b0;
    asm_byte_valid = 1'b0;
    if (operand_valid) begin
`ifdef ALU_CMD_MUL_EN
      acc_d = is_mul ? acc_q * operand : acc_q + operand;
`else
      acc_d = acc_q + operand;
`endif
    end
    case (state_q)
      ST_HDR0: if (rx_fire) begin
        opcode_d = bus.rx_tdata_i[7:0];
        state_d  = ST_HDR1;
      end
      ST_HDR1: if (rx_fire) state_d = ST_HDR2;
      ST_HDR2: if (rx_fire) begin
        len_lo_d = bus.rx_tdata_i[7:0];
        state_d  = ST_HDR3;
      end
      ST_HDR3: if (rx_fire) begin
        asm_clear = 1'b1;
        acc_d     = is_mul ? ACC_WIDTH_P'(1) : '0;
        ridx_d    = '0;
        // Counter holds remaining payload bytes; short lengths collapse to header only.
        if (len_full > HDR_LEN) begin
          cnt_d   = len_full - HDR_LEN;
          state_d = ST_PAYLOAD;
        end else begin
          cnt_d   = '0;
          state_d = is_arith ? ST_RESP : ST_HDR0;
        end
      end
      ST_PAYLOAD: if (rx_fire) begin
        asm_byte_valid = is_arith;
        cnt_d          = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = is_arith ? ST_RESP : ST_HDR0;
      end
      ST_RESP: if (tx_fire) begin
        if (ridx_q == RIDX_W'(NBYTES - 1)) begin
          ridx_d  = '0;
          state_d = ST_HDR0;
        end else begin
          ridx_d  = ridx_q + RIDX_W'(1);
        end
      end
      default: state_d = ST_HDR0;
    endcase
  end

  // Response waits while the final operand is still being folded into the accumulator.
  always_comb begin
    bus.rx_tready_o = 1'b0;
    bus.tx_tvalid_o = 1'b0;
    bus.tx_tdata_o  = '0;
    busy_o          = 1'b0;
    if (!rst) begin
      busy_o = (state_q != ST_HDR0);
      case (state_q)
        ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3: bus.rx_tready_o = 1'b1;
        ST_PAYLOAD: begin
          if (is_echo) begin
            bus.rx_tready_o = bus.tx_tready_i;
            bus.tx_tvalid_o = bus.rx_tvalid_i;
            bus.tx_tdata_o  = bus.rx_tdata_i;
          end else begin
            bus.rx_tready_o = 1'b1;
          end
        end
        ST_RESP: begin
          bus.tx_tvalid_o = !operand_valid;
          bus.tx_tdata_o  = DATA_WIDTH_P'(acc_q >> (32'(ridx_q) * DATA_WIDTH_P));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Scoreboard bench for alu_cmd_responder: packets are modelled at byte level
// into an expected queue; a monitor compares every accepted tx byte.
module tb_alu_cmd_responder;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  alu_cmd_responder_if #(.DATA_WIDTH_P(DW)) bus ();

  alu_cmd_responder #(
    .DATA_WIDTH_P (DW),
    .ACC_WIDTH_P  (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_q[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  int          tmode = 0;        // 0 ready, 1 random, 2 toggle, 3 manual
  logic        manual_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got %0h expected %0h", name, got, exp);
  endtask

  task automatic abort_run(input string name);
    checks++;
    $display("FAIL %s got timeout expected handshake", name);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Reference: length rules, echo payload, or sum/product of complete LE words.
  function automatic void model(input logic [7:0] p[$]);
    int unsigned len, plen, nops;
    logic [31:0] acc, opnd;
    bit arith, mul;
    len   = {p[3], p[2]};
    plen  = (len > 4) ? len - 4 : 0;
    mul   = 1'b0;
`ifdef ALU_CMD_MUL_EN
    mul   = (p[0] == 8'hB0);
`endif
    arith = (p[0] == 8'hA0) || mul;
    if (p[0] == 8'hEC) begin
      for (int unsigned i = 0; i < plen; i++) exp_q.push_back(p[4+i]);
    end else if (arith) begin
      acc  = mul ? 32'd1 : 32'd0;
      nops = plen / 4;
      for (int unsigned k = 0; k < nops; k++) begin
        opnd = {p[4+4*k+3], p[4+4*k+2], p[4+4*k+1], p[4+4*k]};
        acc  = mul ? acc * opnd : acc + opnd;
      end
      for (int unsigned b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8*b)));
    end
  endfunction

  always @(negedge clk) begin
    case (tmode)
      0: bus.tx_tready_i = 1'b1;
      1: bus.tx_tready_i = 1'($urandom_range(0, 1));
      2: bus.tx_tready_i = ~bus.tx_tready_i;
      default: bus.tx_tready_i = manual_ready;
    endcase
  end

  // Monitor: a byte counts as transferred when valid and ready are both seen
  // ahead of the rising edge; a stalled byte must stay put.
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    logic [7:0] e;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", 32'(bus.tx_tvalid_o), 32'd1);
          check("hold_data", 32'(bus.tx_tdata_o), 32'(pend_data));
        end
        if (bus.tx_tvalid_o && bus.tx_tready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_tx got %0h expected none", bus.tx_tdata_o);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(bus.tx_tdata_o), 32'(e));
          end
          pend = 1'b0;
        end else if (bus.tx_tvalid_o) begin
          pend      = 1'b1;
          pend_data = bus.tx_tdata_o;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned n;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.rx_tvalid_i = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_tdata_i  = b;
    bus.rx_tvalid_i = 1'b1;
    n = 0;
    #1;
    while (!bus.rx_tready_o) begin
      n++;
      if (n > 300) abort_run("rx_stall");
      @(negedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] p[$], input bit gaps);
    @(negedge clk);
    foreach (p[i]) send_byte(p[i], gaps);
    bus.rx_tvalid_i = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] p[$], input bit gaps);
    model(p);
    send_raw(p, gaps);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    #3;
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] p[$];
    int unsigned len, eff, n;
    logic [7:0] op;

    bus.rx_tdata_i  = '0;
    bus.rx_tvalid_i = 1'b0;
    bus.tx_tready_i = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_rx_tready", 32'(bus.rx_tready_o), 32'd0);
    check("rst_tx_tvalid", 32'(bus.tx_tvalid_o), 32'd0);
    check("rst_tx_tdata",  32'(bus.tx_tdata_o),  32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("ready_after_rst", 32'(bus.rx_tready_o), 32'd1);

    p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_packet(p, 1'b0); drain(); check_idle("echo_idle");

    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_packet(p, 1'b0); drain(); check_idle("add_wrap_idle");

    p = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09};
    send_packet(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    send_packet(p, 1'b0); drain();

    p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_packet(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_packet(p, 1'b0); drain(); check_idle("unknown_idle");

    p = '{8'hA0, 8'h00, 8'h02, 8'h00};
    send_packet(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h03, 8'h00};
    send_packet(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h00, 8'h00};
    send_packet(p, 1'b0); drain(); check_idle("short_len_idle");

    tmode = 2;
    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_packet(p, 1'b0); drain();
    tmode = 0;

`ifdef ALU_CMD_MUL_EN
    p = '{8'hB0, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_packet(p, 1'b0); drain();
    p = '{8'hB0, 8'h00, 8'h04, 8'h00};
    send_packet(p, 1'b0); drain();
`endif

    // Abort a response after one byte: the rest must never appear.
    manual_ready = 1'b0;
    tmode = 3;
    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'h03);
    send_raw(p, 1'b0);
    n = 0;
    #3;
    while (!bus.tx_tvalid_o && n < 50) begin
      @(negedge clk); #3; n++;
    end
    check("resp_valid_seen", 32'(bus.tx_tvalid_o), 32'd1);
    manual_ready = 1'b1;
    @(negedge clk); #3;
    manual_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("midrst_tx_tvalid", 32'(bus.tx_tvalid_o), 32'd0);
    check("midrst_tx_tdata",  32'(bus.tx_tdata_o),  32'd0);
    check("midrst_rx_tready", 32'(bus.rx_tready_o), 32'd0);
    check("midrst_busy",      32'(busy),            32'd0);
    check("midrst_first_byte", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tmode = 0;
    #3;
    check("midrst_ready_after", 32'(bus.rx_tready_o), 32'd1);
    repeat (4) begin
      @(negedge clk); #3;
      check("no_stale_tx", 32'(bus.tx_tvalid_o), 32'd0);
    end
    p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_packet(p, 1'b0); drain();

    tmode = 1;
    for (int unsigned t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'hB0;
        3: op = 8'($urandom);
        default: op = 8'hA0;
      endcase
      len = $urandom_range(0, 22);
      eff = (len < 4) ? 4 : len;
      p = {};
      p.push_back(op);
      p.push_back(8'($urandom));
      p.push_back(8'(len));
      p.push_back(8'(len >> 8));
      for (int unsigned i = 4; i < eff; i++) p.push_back(8'($urandom));
      send_packet(p, 1'b1);
    end
    drain();
    tmode = 0;
    check_idle("random_idle");

    // Maximum length: exactly 0xFFFB payload bytes, then a packet must realign.
    p = {};
    p.push_back(8'h55); p.push_back(8'h00); p.push_back(8'hFF); p.push_back(8'hFF);
    for (int unsigned i = 0; i < 32'hFFFB; i++) p.push_back(8'($urandom));
    send_packet(p, 1'b0);
    p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h3C, 8'hC3};
    send_packet(p, 1'b0); drain(); check_idle("maxlen_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
